// File: rtl/vram_arbiter.sv
// vram_arbiter: merges a CPU byte port and a pipelined display fetch port
// onto the single 32-bit video RAM port. The display port normally wins,
// and a saturating wait counter bounds how long a pending CPU access can lose.
module vram_arbiter #(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_write,
  input  logic        cpu_strobe,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rddata,
  input  logic        lb_req,
  input  logic [14:0] lb_addr,
  output logic        lb_gnt,
  output logic        lb_rdvalid,
  output logic [31:0] lb_rddata,
  output logic [14:0] ram_addr,
  output logic [31:0] ram_wrdata,
  output logic [3:0]  ram_wrbytesel,
  output logic        ram_write,
  input  logic [31:0] ram_rddata
);

  localparam logic [3:0] MaxWait = 4'(CPU_MAX_WAIT);

  logic [16:0] addr_q;
  logic [7:0]  wrdata_q;
  logic        write_q;
  logic [3:0]  wait_cnt;
  logic        cpu_win;
  logic        rd_tag;
  logic [1:0]  lane_q;
  logic [7:0]  rddata_q;
  logic [7:0]  lane_byte;
  logic [14:0] addr_last;

  // CPU wins when it is pending and either the display is idle or it has waited long enough
  always_comb begin
    cpu_win = cpu_busy && (!lb_req || (wait_cnt == MaxWait));
  end

  assign lb_gnt = lb_req && !cpu_win && rst_n;

  // Drive the RAM port from whichever requester holds the grant this cycle
  always_comb begin
    ram_addr      = addr_last;
    ram_wrdata    = {4{wrdata_q}};
    ram_wrbytesel = 4'b0000;
    ram_write     = 1'b0;
    if (cpu_win) begin
      ram_addr      = addr_q[16:2];
      ram_wrbytesel = 4'b0001 << addr_q[1:0];
      ram_write     = write_q;
    end else if (lb_gnt) begin
      ram_addr = lb_addr;
    end
  end

  // Pick the CPU byte lane out of the word the RAM returns
  always_comb begin
    lane_byte = ram_rddata[7:0];
    case (lane_q)
      2'd0: lane_byte = ram_rddata[7:0];
      2'd1: lane_byte = ram_rddata[15:8];
      2'd2: lane_byte = ram_rddata[23:16];
      2'd3: lane_byte = ram_rddata[31:24];
      default: lane_byte = ram_rddata[7:0];
    endcase
  end

  // Read data arrives the cycle after the grant, so it is steered straight through on the ack cycle
  assign cpu_rddata = (cpu_ack && rd_tag) ? lane_byte : rddata_q;
  assign lb_rddata  = lb_rdvalid ? ram_rddata : 32'h0;

  // CPU request capture, pending flag and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy <= 1'b0;
      addr_q   <= 17'h0;
      wrdata_q <= 8'h0;
      write_q  <= 1'b0;
      wait_cnt <= 4'h0;
    end else if (cpu_win) begin
      cpu_busy <= 1'b0;
      wait_cnt <= 4'h0;
    end else begin
      if (cpu_busy && (wait_cnt != MaxWait)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (cpu_strobe && !cpu_busy) begin
        cpu_busy <= 1'b1;
        addr_q   <= cpu_addr;
        wrdata_q <= cpu_wrdata;
        write_q  <= cpu_write;
      end
    end
  end

  // In-flight tags: which port was granted last cycle, and for a CPU read which lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack    <= 1'b0;
      rd_tag     <= 1'b0;
      lane_q     <= 2'd0;
      lb_rdvalid <= 1'b0;
    end else begin
      cpu_ack    <= cpu_win;
      rd_tag     <= cpu_win && !write_q;
      lb_rdvalid <= lb_gnt;
      if (cpu_win) begin
        lane_q <= addr_q[1:0];
      end
    end
  end

  // Hold the last CPU read byte and the last granted RAM address between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddata_q  <= 8'h0;
      addr_last <= 15'h0;
    end else begin
      if (cpu_ack && rd_tag) begin
        rddata_q <= lane_byte;
      end
      if (cpu_win || lb_gnt) begin
        addr_last <= ram_addr;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with a RAM model and scoreboard queues
// for CPU acks and display fetch returns.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_write;
  logic        cpu_strobe;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [7:0]  cpu_rddata;
  logic        lb_req;
  logic [14:0] lb_addr;
  logic        lb_gnt;
  logic        lb_rdvalid;
  logic [31:0] lb_rddata;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  typedef struct {
    logic       rd;
    logic [7:0] data;
  } cpu_exp_t;

  cpu_exp_t    cpu_q[$];
  logic [31:0] lb_q[$];
  logic [31:0] mem     [0:32767];
  logic [31:0] exp_mem [0:32767];
  logic [7:0]  last_rd = 8'h0;
  int          checks = 0;
  int          errors = 0;
  int          lb_seen = 0;

  vram_arbiter #(.CPU_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_write(cpu_write),
    .cpu_strobe(cpu_strobe), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .cpu_rddata(cpu_rddata),
    .lb_req(lb_req), .lb_addr(lb_addr), .lb_gnt(lb_gnt),
    .lb_rdvalid(lb_rdvalid), .lb_rddata(lb_rddata),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  // Video RAM model: byte-enabled write, registered read one cycle after the address
  always @(posedge clk) begin
    if (ram_write) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wrbytesel[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
      end
    end
    ram_rddata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Drive a CPU strobe and record what its ack must carry
  task automatic applyStimulus(input logic [16:0] a, input logic [7:0] d, input logic wr);
    cpu_exp_t e;
    cpu_addr   = a;
    cpu_wrdata = d;
    cpu_write  = wr;
    cpu_strobe = 1'b1;
    e.rd   = !wr;
    e.data = exp_mem[a[16:2]][8*a[1:0] +: 8];
    if (wr) exp_mem[a[16:2]][8*a[1:0] +: 8] = d;
    cpu_q.push_back(e);
  endtask

  // Scoreboard: compare each ack / fetch return against the queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checkOutput("cpu_ack_unexpected", {31'h0, cpu_ack}, 32'h0);
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          if (e.rd) begin
            checkOutput("cpu_rddata", {24'h0, cpu_rddata}, {24'h0, e.data});
            last_rd = e.data;
          end else begin
            checkOutput("cpu_rddata_held_on_write", {24'h0, cpu_rddata}, {24'h0, last_rd});
          end
        end
      end
      if (lb_rdvalid) begin
        lb_seen++;
        if (lb_q.size() == 0) begin
          checkOutput("lb_rdvalid_unexpected", {31'h0, lb_rdvalid}, 32'h0);
        end else begin
          checkOutput("lb_rddata", lb_rddata, lb_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     <= 32'(i) * 32'h9E3779B1 + 32'h01010101;
      exp_mem[i]  = 32'(i) * 32'h9E3779B1 + 32'h01010101;
    end
    mem[3]     <= 32'h44332211;
    exp_mem[3]  = 32'h44332211;
    rst_n = 1'b0;
    cpu_addr = '0; cpu_wrdata = '0; cpu_write = 1'b0; cpu_strobe = 1'b0;
    lb_req = 1'b1; lb_addr = 15'h0;
    $display("[TB] reset checks");
    nextCycle(); nextCycle(); #1;
    checkOutput("rst_lb_gnt", {31'h0, lb_gnt}, 32'h0);
    checkOutput("rst_ram_write", {31'h0, ram_write}, 32'h0);
    checkOutput("rst_cpu_busy", {31'h0, cpu_busy}, 32'h0);
    checkOutput("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    checkOutput("rst_cpu_rddata", {24'h0, cpu_rddata}, 32'h0);
    checkOutput("rst_lb_rdvalid", {31'h0, lb_rdvalid}, 32'h0);
    checkOutput("rst_lb_rddata", lb_rddata, 32'h0);
    lb_req = 1'b0;
    rst_n = 1'b1;
    nextCycle(); #1;
    checkOutput("idle_ram_write", {31'h0, ram_write}, 32'h0);
    checkOutput("idle_lb_gnt", {31'h0, lb_gnt}, 32'h0);
    checkOutput("idle_cpu_ack", {31'h0, cpu_ack}, 32'h0);

    $display("[TB] CPU write 0xA5 to 0x12345");
    nextCycle(); applyStimulus(17'h12345, 8'hA5, 1'b1);
    nextCycle(); cpu_strobe = 1'b0; #1;
    checkOutput("wr_busy", {31'h0, cpu_busy}, 32'h1);
    checkOutput("wr_ram_addr", {17'h0, ram_addr}, 32'h48D1);
    checkOutput("wr_bytesel", {28'h0, ram_wrbytesel}, 32'h2);
    checkOutput("wr_wrdata", ram_wrdata, 32'hA5A5A5A5);
    checkOutput("wr_ram_write", {31'h0, ram_write}, 32'h1);
    nextCycle(); #1;
    checkOutput("wr_ack", {31'h0, cpu_ack}, 32'h1);
    checkOutput("wr_busy_clear", {31'h0, cpu_busy}, 32'h0);

    $display("[TB] CPU read of 0x0000F");
    nextCycle(); applyStimulus(17'h0000F, 8'h00, 1'b0);
    nextCycle(); cpu_strobe = 1'b0; #1;
    checkOutput("rd_ram_addr", {17'h0, ram_addr}, 32'h0003);
    checkOutput("rd_ram_write", {31'h0, ram_write}, 32'h0);
    nextCycle(); #1;
    checkOutput("rd_ack", {31'h0, cpu_ack}, 32'h1);
    nextCycle(); nextCycle(); #1;
    checkOutput("rd_data_held", {24'h0, cpu_rddata}, 32'h44);

    $display("[TB] display burst 0x100..0x102");
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      lb_req = 1'b1; lb_addr = 15'h100 + 15'(k); #1;
      checkOutput("burst_lb_gnt", {31'h0, lb_gnt}, 32'h1);
      lb_q.push_back(exp_mem[lb_addr]);
    end
    nextCycle(); lb_req = 1'b0;
    nextCycle();
    checkOutput("burst_count", 32'(lb_seen), 32'd3);

    $display("[TB] CPU read starved by display, CPU_MAX_WAIT=4");
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      cpu_strobe = 1'b0;
      if (k == 0) applyStimulus(17'h0000C, 8'h00, 1'b0);
      lb_req = 1'b1; lb_addr = 15'h200 + 15'(k); #1;
      checkOutput("starve_lb_gnt", {31'h0, lb_gnt}, {31'h0, k != 5});
      checkOutput("starve_busy", {31'h0, cpu_busy}, {31'h0, k >= 1 && k <= 5});
      checkOutput("starve_ack", {31'h0, cpu_ack}, {31'h0, k == 6});
      if (k == 5) checkOutput("starve_ram_addr", {17'h0, ram_addr}, 32'h0003);
      if (lb_gnt) lb_q.push_back(exp_mem[lb_addr]);
    end
    nextCycle(); lb_req = 1'b0;

    $display("[TB] second strobe while busy");
    nextCycle(); applyStimulus(17'h00004, 8'h3C, 1'b0 | 1'b1);
    nextCycle(); cpu_addr = 17'h00100; cpu_write = 1'b0; #1;
    checkOutput("dbl_ram_addr", {17'h0, ram_addr}, 32'h0001);
    nextCycle(); cpu_strobe = 1'b0;
    nextCycle(); nextCycle(); #1;
    checkOutput("dbl_busy_idle", {31'h0, cpu_busy}, 32'h0);

    $display("[TB] write 0x1FFFF then display read of the same word");
    nextCycle(); applyStimulus(17'h1FFFF, 8'h5A, 1'b1);
    nextCycle(); cpu_strobe = 1'b0; #1;
    checkOutput("top_ram_addr", {17'h0, ram_addr}, 32'h7FFF);
    checkOutput("top_bytesel", {28'h0, ram_wrbytesel}, 32'h8);
    nextCycle(); lb_req = 1'b1; lb_addr = 15'h7FFF; #1;
    checkOutput("top_lb_gnt", {31'h0, lb_gnt}, 32'h1);
    lb_q.push_back(exp_mem[15'h7FFF]);
    nextCycle(); lb_req = 1'b0;
    nextCycle();

    $display("[TB] reset between read grant and ack");
    nextCycle(); applyStimulus(17'h00010, 8'h00, 1'b0);
    nextCycle(); cpu_strobe = 1'b0; #1;
    checkOutput("rstmid_ram_addr", {17'h0, ram_addr}, 32'h0004);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_q.delete();
    last_rd = 8'h0;
    #2 rst_n = 1'b1;
    nextCycle(); #1;
    checkOutput("rstmid_ack", {31'h0, cpu_ack}, 32'h0);
    checkOutput("rstmid_rddata", {24'h0, cpu_rddata}, 32'h0);
    checkOutput("rstmid_busy", {31'h0, cpu_busy}, 32'h0);
    nextCycle(); nextCycle();

    for (int i = 0; i < 20 && (cpu_q.size() != 0 || lb_q.size() != 0); i++) nextCycle();
    checkOutput("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    checkOutput("lb_q_drained", 32'(lb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
